// File: rtl/kp_midi_pkg.sv
// kp_midi_pkg: shared types and constants for the MIDI voice controller.
//   - parser / trigger-sequencer / running-status state enums
//   - MIDI status constants
//   - NOTE_DELAY: note number -> delay length in samples at 96 kHz,
//     min(4095, round(96000 / f(note))), A4 (note 69) = 218
package kp_midi_pkg;

  typedef enum logic [2:0] {P_IDLE, P_D1, P_D2, P_SKIP, P_SYSEX} parse_state_t;
  typedef enum logic [1:0] {T_IDLE, T_SETUP, T_HIGH, T_GAP} trig_state_t;
  typedef enum logic [1:0] {RS_NONE, RS_OWN, RS_FOREIGN} run_status_t;

  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [7:0] SYSEX    = 8'hF0;
  localparam logic [7:0] RT_MIN   = 8'hF8;

  localparam logic [11:0] NOTE_DELAY [0:127] = '{
    // 0..18 clamp to the 12-bit maximum
    12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095,
    12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095,
    12'd4095, 12'd4095, 12'd4095,
    // 19..30
    12'd3918, 12'd3698, 12'd3491, 12'd3295, 12'd3110, 12'd2935,
    12'd2771, 12'd2615, 12'd2468, 12'd2330, 12'd2199, 12'd2076,
    // 31..42
    12'd1959, 12'd1849, 12'd1745, 12'd1647, 12'd1555, 12'd1468,
    12'd1385, 12'd1308, 12'd1234, 12'd1165, 12'd1100, 12'd1038,
    // 43..54
    12'd980,  12'd925,  12'd873,  12'd824,  12'd778,  12'd734,
    12'd693,  12'd654,  12'd617,  12'd582,  12'd550,  12'd519,
    // 55..66
    12'd490,  12'd462,  12'd436,  12'd412,  12'd389,  12'd367,
    12'd346,  12'd327,  12'd309,  12'd291,  12'd275,  12'd259,
    // 67..78
    12'd245,  12'd231,  12'd218,  12'd206,  12'd194,  12'd183,
    12'd173,  12'd163,  12'd154,  12'd146,  12'd137,  12'd130,
    // 79..90
    12'd122,  12'd116,  12'd109,  12'd103,  12'd97,   12'd92,
    12'd87,   12'd82,   12'd77,   12'd73,   12'd69,   12'd65,
    // 91..102
    12'd61,   12'd58,   12'd55,   12'd51,   12'd49,   12'd46,
    12'd43,   12'd41,   12'd39,   12'd36,   12'd34,   12'd32,
    // 103..114
    12'd31,   12'd29,   12'd27,   12'd26,   12'd24,   12'd23,
    12'd22,   12'd20,   12'd19,   12'd18,   12'd17,   12'd16,
    // 115..126
    12'd15,   12'd14,   12'd14,   12'd13,   12'd12,   12'd11,
    12'd11,   12'd10,   12'd10,   12'd9,    12'd9,    12'd8,
    // 127
    12'd8
  };

  // System realtime bytes may appear anywhere and are transparent to parsing.
  function automatic logic is_realtime(input logic [7:0] b);
    return (b >= RT_MIN);
  endfunction

endpackage

// File: rtl/kp_note_rom.sv
// kp_note_rom: registered note-to-delay lookup, one cycle latency.
//   a_clk   in   clock
//   reset_n in   synchronous active-low reset (output returns to A4 = 218)
//   note    in   7-bit MIDI note number
//   delay   out  12-bit delay length in samples
module kp_note_rom
  import kp_midi_pkg::*;
(
  input  logic        a_clk,
  input  logic        reset_n,
  input  logic [6:0]  note,
  output logic [11:0] delay
);

  // Table lookup register.
  always_ff @(posedge a_clk) begin
    if (!reset_n) begin
      delay <= 12'd218;
    end else begin
      delay <= NOTE_DELAY[note];
    end
  end

endmodule

// File: rtl/kp_midi_voice_ctrl.sv
// kp_midi_voice_ctrl: MIDI note-on/note-off front end for the Karplus-Strong
// voice. Parses the byte stream (running status, realtime, sysex, foreign
// messages), maps the note to a delay length and sequences trig so the voice
// always sees a debounce-safe pulse with delay_length settled while trig is low.
//   a_clk        in   96 kHz audio clock
//   reset_n      in   synchronous active-low reset
//   rx_byte      in   MIDI byte, valid with rx_valid (strobes >= 2 cycles apart)
//   channel      in   MIDI channel to respond to
//   decay_base   in   sustain decay applied on note-on
//   trig         out  voice trigger level
//   velocity     out  velocity of the current note
//   delay_length out  samples per period of the current note
//   decay        out  voice decay gain
//   busy         out  trig sequencer active
//   cur_note     out  current note number
// Optional feature macro: KP_NOTE_OFF_DAMP_EN (note-off of the current note
// switches decay to DAMP_DECAY).
module kp_midi_voice_ctrl #(
  parameter int          SETUP_CYC  = 2,
  parameter int          TRIG_LEN   = 8,
  parameter int          GAP_CYC    = 8,
  parameter logic [11:0] DAMP_DECAY = 12'd2048
) (
  input  logic        a_clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic [3:0]  channel,
  input  logic [11:0] decay_base,
  output logic        trig,
  output logic [6:0]  velocity,
  output logic [11:0] delay_length,
  output logic [11:0] decay,
  output logic        busy,
  output logic [6:0]  cur_note
);
  import kp_midi_pkg::*;

`ifdef KP_NOTE_OFF_DAMP_EN
  localparam logic DAMP_EN = 1'b1;
`else
  localparam logic DAMP_EN = 1'b0;
`endif

  parse_state_t parse_r, parse_next_s;
  run_status_t  rs_r, rs_next_s;
  logic         rs_on_r, rs_on_next_s;     // own running status is 9n (else 8n)
  logic         skip2_r, skip2_next_s;     // foreign message carries 2 data bytes
  logic [1:0]   skip_cnt_r, skip_cnt_next_s;
  logic [6:0]   note_r, note_next_s;
  logic         note_ev_s, note_on_s, note_off_s;
  logic [3:0]   hi_s;

  trig_state_t  seq_r, seq_next_s;
  logic [7:0]   cnt_r, cnt_next_s;
  logic         launch_s, take_pend_s, pend_v_r, pend_v_next_s, damp_s;
  logic [6:0]   pend_note_r, pend_vel_r, ld_note_s, ld_vel_s;
  logic [11:0]  pend_delay_r, ld_delay_s, rom_delay_s;

  assign hi_s = rx_byte[7:4];

  kp_note_rom u_rom (
    .a_clk   (a_clk),
    .reset_n (reset_n),
    .note    (note_r),
    .delay   (rom_delay_s)
  );

  // Parser next-state: status bytes always win, data bytes depend on state.
  always_comb begin
    parse_next_s    = parse_r;
    rs_next_s       = rs_r;
    rs_on_next_s    = rs_on_r;
    skip2_next_s    = skip2_r;
    skip_cnt_next_s = skip_cnt_r;
    note_next_s     = note_r;
    note_ev_s       = 1'b0;
    if (rx_valid && !is_realtime(rx_byte)) begin
      if (rx_byte[7]) begin
        if ((hi_s == NOTE_ON || hi_s == NOTE_OFF) && rx_byte[3:0] == channel) begin
          rs_next_s    = RS_OWN;
          rs_on_next_s = (hi_s == NOTE_ON);
          parse_next_s = P_D1;
        end else if (rx_byte == SYSEX) begin
          rs_next_s    = RS_NONE;
          parse_next_s = P_SYSEX;
        end else if (hi_s == 4'hF) begin
          rs_next_s    = RS_NONE;
          parse_next_s = P_IDLE;
        end else begin
          rs_next_s       = RS_FOREIGN;
          skip2_next_s    = !(hi_s == 4'hC || hi_s == 4'hD);
          skip_cnt_next_s = (hi_s == 4'hC || hi_s == 4'hD) ? 2'd1 : 2'd2;
          parse_next_s    = P_SKIP;
        end
      end else begin
        case (parse_r)
          P_IDLE: begin
            if (rs_r == RS_OWN) begin
              note_next_s  = rx_byte[6:0];
              parse_next_s = P_D2;
            end else if (rs_r == RS_FOREIGN && skip2_r) begin
              // this byte is the first of a new foreign message
              skip_cnt_next_s = 2'd1;
              parse_next_s    = P_SKIP;
            end else begin
              parse_next_s = P_IDLE;
            end
          end
          P_D1: begin
            note_next_s  = rx_byte[6:0];
            parse_next_s = P_D2;
          end
          P_D2: begin
            note_ev_s    = 1'b1;
            parse_next_s = P_IDLE;
          end
          P_SKIP: begin
            skip_cnt_next_s = skip_cnt_r - 2'd1;
            if (skip_cnt_r <= 2'd1) begin
              parse_next_s = P_IDLE;
            end else begin
              parse_next_s = P_SKIP;
            end
          end
          P_SYSEX: parse_next_s = P_SYSEX;
          default: parse_next_s = P_IDLE;
        endcase
      end
    end else begin
      parse_next_s = parse_r;
    end
  end

  assign note_on_s  = note_ev_s & rs_on_r & (rx_byte[6:0] != 7'd0);
  assign note_off_s = note_ev_s & ~note_on_s;
  assign damp_s     = DAMP_EN & note_off_s & (note_r == cur_note) & ~pend_v_r;

  // Parser state registers.
  always_ff @(posedge a_clk) begin
    if (!reset_n) begin
      parse_r    <= P_IDLE;
      rs_r       <= RS_NONE;
      rs_on_r    <= 1'b0;
      skip2_r    <= 1'b0;
      skip_cnt_r <= 2'd0;
      note_r     <= 7'd69;
    end else begin
      parse_r    <= parse_next_s;
      rs_r       <= rs_next_s;
      rs_on_r    <= rs_on_next_s;
      skip2_r    <= skip2_next_s;
      skip_cnt_r <= skip_cnt_next_s;
      note_r     <= note_next_s;
    end
  end

  // Trig sequencer next-state; a note-on coinciding with the end of the gap
  // launches directly and supersedes any pending note.
  always_comb begin
    seq_next_s    = seq_r;
    cnt_next_s    = cnt_r;
    launch_s      = 1'b0;
    take_pend_s   = 1'b0;
    pend_v_next_s = pend_v_r;
    case (seq_r)
      T_IDLE: begin
        if (note_on_s) begin
          launch_s = 1'b1;
        end else begin
          launch_s = 1'b0;
        end
      end
      T_SETUP: begin
        if (cnt_r == 8'd0) begin
          seq_next_s = T_HIGH;
          cnt_next_s = 8'(TRIG_LEN - 1);
        end else begin
          cnt_next_s = cnt_r - 8'd1;
        end
      end
      T_HIGH: begin
        if (cnt_r == 8'd0) begin
          seq_next_s = T_GAP;
          cnt_next_s = 8'(GAP_CYC - 1);
        end else begin
          cnt_next_s = cnt_r - 8'd1;
        end
      end
      T_GAP: begin
        if (cnt_r != 8'd0) begin
          cnt_next_s = cnt_r - 8'd1;
        end else if (note_on_s) begin
          launch_s = 1'b1;
        end else if (pend_v_r) begin
          launch_s    = 1'b1;
          take_pend_s = 1'b1;
        end else begin
          seq_next_s = T_IDLE;
        end
      end
      default: seq_next_s = T_IDLE;
    endcase
    if (launch_s) begin
      seq_next_s    = T_SETUP;
      cnt_next_s    = 8'(SETUP_CYC - 1);
      pend_v_next_s = 1'b0;
    end else if (note_on_s) begin
      pend_v_next_s = 1'b1;
    end else begin
      pend_v_next_s = pend_v_r;
    end
  end

  // Source of the note being launched.
  always_comb begin
    ld_note_s  = note_r;
    ld_vel_s   = rx_byte[6:0];
    ld_delay_s = rom_delay_s;
    if (take_pend_s) begin
      ld_note_s  = pend_note_r;
      ld_vel_s   = pend_vel_r;
      ld_delay_s = pend_delay_r;
    end else begin
      ld_note_s  = note_r;
      ld_vel_s   = rx_byte[6:0];
      ld_delay_s = rom_delay_s;
    end
  end

  // Sequencer state and single-depth pending note.
  always_ff @(posedge a_clk) begin
    if (!reset_n) begin
      seq_r        <= T_IDLE;
      cnt_r        <= 8'd0;
      pend_v_r     <= 1'b0;
      pend_note_r  <= 7'd0;
      pend_vel_r   <= 7'd0;
      pend_delay_r <= 12'd0;
    end else begin
      seq_r    <= seq_next_s;
      cnt_r    <= cnt_next_s;
      pend_v_r <= pend_v_next_s;
      if (note_on_s && !launch_s) begin
        pend_note_r  <= note_r;
        pend_vel_r   <= rx_byte[6:0];
        pend_delay_r <= rom_delay_s;
      end else begin
        pend_note_r  <= pend_note_r;
        pend_vel_r   <= pend_vel_r;
        pend_delay_r <= pend_delay_r;
      end
    end
  end

  // Voice-facing outputs; note parameters only move on a launch, when trig is low.
  always_ff @(posedge a_clk) begin
    if (!reset_n) begin
      trig         <= 1'b0;
      busy         <= 1'b0;
      velocity     <= 7'd0;
      delay_length <= 12'd218;
      decay        <= 12'd0;
      cur_note     <= 7'd69;
    end else begin
      trig <= (seq_next_s == T_HIGH);
      busy <= (seq_next_s != T_IDLE);
      if (launch_s) begin
        velocity     <= ld_vel_s;
        delay_length <= ld_delay_s;
        cur_note     <= ld_note_s;
        decay        <= decay_base;
      end else if (damp_s) begin
        decay <= DAMP_DECAY;
      end else begin
        decay <= decay;
      end
    end
  end

endmodule

// File: tb/tb_kp_midi_voice_ctrl.sv
module tb_kp_midi_voice_ctrl;

`ifdef KP_NOTE_OFF_DAMP_EN
  localparam bit DAMP_EN = 1'b1;
`else
  localparam bit DAMP_EN = 1'b0;
`endif
  localparam int TRIG_LEN = 8;
  localparam int NV = 19;

  logic        a_clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [3:0]  channel;
  logic [11:0] decay_base;
  logic        trig;
  logic [6:0]  velocity;
  logic [11:0] delay_length;
  logic [11:0] decay;
  logic        busy;
  logic [6:0]  cur_note;

  kp_midi_voice_ctrl dut (
    .a_clk        (a_clk),
    .reset_n      (reset_n),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .channel      (channel),
    .decay_base   (decay_base),
    .trig         (trig),
    .velocity     (velocity),
    .delay_length (delay_length),
    .decay        (decay),
    .busy         (busy),
    .cur_note     (cur_note)
  );

  always #5 a_clk = ~a_clk;

  typedef struct {
    logic [6:0]  note;
    logic [6:0]  vel;
    logic [11:0] dly;
  } exp_t;

  typedef struct {
    logic [47:0] bytes;
    int          n;
    logic [3:0]  chan;
    logic [11:0] dbase;
    bit          launch;
    bit          damp;
    logic [6:0]  note;
    logic [6:0]  vel;
    logic [11:0] dly;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[NV];
  int total = 0;
  int bad = 0;
  int pulses = 0;
  int pulses_exp = 0;
  logic [6:0]  e_note;
  logic [6:0]  e_vel;
  logic [11:0] e_dly;
  logic [11:0] e_dec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [47:0] b, input int n, input logic [3:0] c,
                              input logic [11:0] d, input bit l, input bit dm,
                              input logic [6:0] nt, input logic [6:0] vl, input logic [11:0] dl);
    vec_t v;
    v.bytes = b; v.n = n; v.chan = c; v.dbase = d; v.launch = l; v.damp = dm;
    v.note = nt; v.vel = vl; v.dly = dl;
    return v;
  endfunction

  // one byte strobe followed by two idle cycles
  task automatic send(input logic [7:0] b);
    rx_byte = b;
    rx_valid = 1'b1;
    @(posedge a_clk); #1;
    rx_valid = 1'b0;
    rx_byte = 8'h00;
    @(posedge a_clk); #1;
    @(posedge a_clk); #1;
  endtask

  task automatic push_exp(input logic [6:0] n, input logic [6:0] v, input logic [11:0] d);
    exp_t e;
    e.note = n; e.vel = v; e.dly = d;
    sb.push_back(e);
    pulses_exp++;
    e_note = n; e_vel = v; e_dly = d;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    @(negedge a_clk);
    while (busy && k < budget) begin
      @(negedge a_clk);
      k++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pulses"}, pulses, pulses_exp);
    check({tag, "_delay"}, delay_length, e_dly);
    check({tag, "_vel"}, velocity, e_vel);
    check({tag, "_note"}, cur_note, e_note);
    check({tag, "_decay"}, decay, e_dec);
    check({tag, "_trig"}, {31'd0, trig}, 32'd0);
  endtask

  // Trig monitor: scoreboard pop on every rising edge, width and stability checks.
  logic        prev_trig = 1'b0;
  int          hi_cnt = 0;
  logic [11:0] hi_dly = 12'd0;
  exp_t        mon_e;
  always @(negedge a_clk) begin
    if (!reset_n) begin
      prev_trig = 1'b0;
      hi_cnt = 0;
    end else begin
      if (trig && !prev_trig) begin
        pulses++;
        hi_cnt = 0;
        hi_dly = delay_length;
        if (sb.size() == 0) begin
          check("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("rise_delay", delay_length, mon_e.dly);
          check("rise_vel", velocity, mon_e.vel);
          check("rise_note", cur_note, mon_e.note);
        end
      end else if (trig) begin
        check("hi_delay_stable", delay_length, hi_dly);
      end
      if (trig) hi_cnt++;
      if (!trig && prev_trig) check("trig_width", hi_cnt, TRIG_LEN);
      prev_trig = trig;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [7:0] b;
    int k;
    vecs[0]  = mk(48'h3C40_0000_0000, 2, 4'd0, 12'd1000, 1'b1, 1'b0, 7'd60,  7'd64,  12'd367);
    vecs[1]  = mk(48'h9000_5000_0000, 3, 4'd0, 12'd1500, 1'b1, 1'b0, 7'd0,   7'd80,  12'd4095);
    vecs[2]  = mk(48'h9045_0000_0000, 3, 4'd0, 12'd1500, 1'b0, 1'b0, 7'd0,   7'd0,   12'd0);
    vecs[3]  = mk(48'h9000_0000_0000, 3, 4'd0, 12'd1500, 1'b0, 1'b1, 7'd0,   7'd0,   12'd0);
    vecs[4]  = mk(48'h9045_F864_0000, 4, 4'd0, 12'd1000, 1'b1, 1'b0, 7'd69,  7'd100, 12'd218);
    vecs[5]  = mk(48'h9145_6400_0000, 3, 4'd0, 12'd1000, 1'b0, 1'b0, 7'd0,   7'd0,   12'd0);
    vecs[6]  = mk(48'h907F_0100_0000, 3, 4'd0, 12'd800,  1'b1, 1'b0, 7'd127, 7'd1,   12'd8);
    vecs[7]  = mk(48'h8045_4000_0000, 3, 4'd0, 12'd800,  1'b0, 1'b0, 7'd0,   7'd0,   12'd0);
    vecs[8]  = mk(48'h9013_4000_0000, 3, 4'd0, 12'd900,  1'b1, 1'b0, 7'd19,  7'd64,  12'd3918);
    vecs[9]  = mk(48'h8013_0000_0000, 3, 4'd0, 12'd900,  1'b0, 1'b1, 7'd0,   7'd0,   12'd0);
    vecs[10] = mk(48'hC005_4564_0000, 4, 4'd0, 12'd900,  1'b0, 1'b0, 7'd0,   7'd0,   12'd0);
    vecs[11] = mk(48'hF045_64F7_0000, 4, 4'd0, 12'd900,  1'b0, 1'b0, 7'd0,   7'd0,   12'd0);
    vecs[12] = mk(48'h4564_0000_0000, 2, 4'd0, 12'd900,  1'b0, 1'b0, 7'd0,   7'd0,   12'd0);
    vecs[13] = mk(48'h903C_9045_6400, 5, 4'd0, 12'd700,  1'b1, 1'b0, 7'd69,  7'd100, 12'd218);
    vecs[14] = mk(48'hB007_6490_517F, 6, 4'd0, 12'd700,  1'b1, 1'b0, 7'd81,  7'd127, 12'd109);
    vecs[15] = mk(48'h9518_2000_0000, 3, 4'd5, 12'd4095, 1'b1, 1'b0, 7'd24,  7'd32,  12'd2935);
    vecs[16] = mk(48'hE000_903E_2200, 5, 4'd0, 12'd600,  1'b1, 1'b0, 7'd62,  7'd34,  12'd327);
    vecs[17] = mk(48'hF8FF_0000_0000, 2, 4'd0, 12'd600,  1'b0, 1'b0, 7'd0,   7'd0,   12'd0);
    vecs[18] = mk(48'h3C28_0000_0000, 2, 4'd0, 12'd500,  1'b1, 1'b0, 7'd60,  7'd40,  12'd367);

    // reset values
    reset_n = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; channel = 4'd0; decay_base = 12'd0;
    repeat (3) @(posedge a_clk);
    #1;
    @(negedge a_clk);
    e_note = 7'd69; e_vel = 7'd0; e_dly = 12'd218; e_dec = 12'd0;
    check_state("reset");
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(posedge a_clk); #1;
    reset_n = 1'b1;
    @(posedge a_clk); #1;

    // exact cycle timing of a note-on from idle
    decay_base = 12'd1000;
    send(8'h90);
    send(8'h45);
    push_exp(7'd69, 7'd100, 12'd218);
    e_dec = 12'd1000;
    rx_byte = 8'h64; rx_valid = 1'b1;
    @(posedge a_clk); #1;
    rx_valid = 1'b0; rx_byte = 8'h00;
    for (int c = 1; c <= 19; c++) begin
      @(negedge a_clk);
      check($sformatf("timing_trig_c%0d", c), {31'd0, trig}, {31'd0, (c >= 3 && c <= 10)});
      check($sformatf("timing_busy_c%0d", c), {31'd0, busy}, {31'd0, (c <= 18)});
      if (c == 1) begin
        check("timing_vel_c1", velocity, 7'd100);
        check("timing_delay_c1", delay_length, 12'd218);
        check("timing_decay_c1", decay, 12'd1000);
      end
    end
    check_state("timing");

    // table-driven byte sequences, one at a time from idle
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      channel = v.chan;
      decay_base = v.dbase;
      for (int j = 0; j < v.n; j++) begin
        b = v.bytes[47 - 8*j -: 8];
        if (j == v.n - 1 && v.launch) begin
          push_exp(v.note, v.vel, v.dly);
          e_dec = v.dbase;
        end
        send(b);
      end
      if (!v.launch && v.damp && DAMP_EN) e_dec = 12'd2048;
      wait_idle($sformatf("v%0d_idle", i), 60);
      check_state($sformatf("v%0d", i));
    end

    // pending: second note-on is overwritten by the third, which plays after the gap
    decay_base = 12'd1000;
    send(8'h90);
    send(8'h45);
    push_exp(7'd69, 7'd100, 12'd218);
    send(8'h64);
    send(8'h3C);
    send(8'h50);
    send(8'h30);
    push_exp(7'd48, 7'd32, 12'd734);
    e_dec = 12'd1000;
    send(8'h20);
    wait_idle("pend_idle", 100);
    check_state("pend");
    check("pend_sb_empty", sb.size(), 32'd0);

    // reset while trig is high
    send(8'h90);
    send(8'h3C);
    push_exp(7'd60, 7'd64, 12'd367);
    send(8'h40);
    k = 0;
    while (!trig && k < 20) begin
      @(negedge a_clk);
      k++;
    end
    check("rst_trig_seen", {31'd0, trig}, 32'd1);
    @(posedge a_clk); #1;
    reset_n = 1'b0;
    @(posedge a_clk);
    @(negedge a_clk);
    e_note = 7'd69; e_vel = 7'd0; e_dly = 12'd218; e_dec = 12'd0;
    check_state("rst_mid");
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    @(posedge a_clk); #1;
    reset_n = 1'b1;
    @(posedge a_clk); #1;
    send(8'h45);
    send(8'h64);
    repeat (12) @(posedge a_clk);
    wait_idle("post_rst_idle", 5);
    check_state("post_rst");
    check("final_sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
